// File: rtl/reg_pkg.sv
// ============================================================================
//  reg_pkg : shared constants and helpers for the reg_pipe register pipeline
//  Revision: 1.0
// ============================================================================
`default_nettype none

package reg_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to hold any occupancy value 0..depth.
  function automatic int cnt_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < (depth + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_pipe_if.sv
// ============================================================================
//  reg_pipe_if : producer/consumer handshake bundle for reg_pipe
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_pipe_if
  import reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
);

  localparam int CW = cnt_width(DEPTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

`default_nettype wire

// File: rtl/reg_pipe_stage.sv
// ============================================================================
//  reg_pipe_stage : one valid+data slot of the stallable register pipeline
//  Revision: 1.0
// ============================================================================
`default_nettype none

module reg_pipe_stage
  import reg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             CLK,
  input  wire logic             reset_n,
  input  wire logic             flush,
  input  wire logic             up_valid,
  input  wire logic [WIDTH-1:0] up_data,
  input  wire logic             dn_ready,
  output logic                  valid,
  output logic [WIDTH-1:0]      data,
  output logic                  rdy
);

  assign rdy = ~valid | dn_ready;

  // Data only moves with a valid word so an emptied slot keeps its last value.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_pipe.sv
// ============================================================================
//  reg_pipe : DEPTH-stage WIDTH-bit valid/ready register pipeline with flush
//  Revision: 1.0
// ============================================================================
`default_nettype none

module reg_pipe
  import reg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input wire logic   CLK,
  input wire logic   reset_n,
  reg_pipe_if.slave  bus
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic             accept;
  logic             pop;
  logic [CW-1:0]    count_q;

  assign rdy[DEPTH]    = bus.out_ready;
  assign bus.in_ready  = rdy[0] & ~bus.flush;
  assign bus.out_valid = valid[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];
  assign bus.count     = count_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = valid[DEPTH-1] & bus.out_ready;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;

      if (i == 0) begin : g_head
        assign up_valid = bus.in_valid;
        assign up_data  = bus.in_data;
      end else begin : g_link
        assign up_valid = valid[i-1];
        assign up_data  = data[i-1];
      end

      reg_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .flush    (bus.flush),
        .up_valid (up_valid),
        .up_data  (up_data),
        .dn_ready (rdy[i+1]),
        .valid    (valid[i]),
        .data     (data[i]),
        .rdy      (rdy[i])
      );
    end
  endgenerate

  // Tracks popcount(valid) incrementally; simultaneous push and pop cancel.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else if (accept && !pop) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !accept) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_pipe.sv
// ============================================================================
//  tb_reg_pipe : scoreboard bench for reg_pipe (8x4 instance and 16x1 instance)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_pipe;

  logic CLK = 1'b0;
  logic reset_n;
  always #5 CLK = ~CLK;

  reg_pipe_if #(.WIDTH(8),  .DEPTH(4)) bus0 ();
  reg_pipe_if #(.WIDTH(16), .DEPTH(1)) bus1 ();

  reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut0 (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  reg_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h0000)) u_dut1 (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a negedge; samples the handshake 1ns before the rising edge.
  task automatic cycle(input int pre = 4);
    #(pre);
    if (bus0.out_valid && bus0.out_ready) begin
      check_eq("pop_has_exp", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_word = sb.pop_front();
        check_eq("pop_data", 32'(bus0.out_data), 32'(exp_word));
      end
    end
    if (bus0.flush) begin
      sb.delete();
    end else if (bus0.in_valid && bus0.in_ready) begin
      sb.push_back(bus0.in_data);
    end
    @(negedge CLK);
    check_eq("count", 32'(bus0.count), 32'(sb.size()));
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      cycle();
    end
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    bus0.flush     = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = '0;
    bus0.out_ready = 1'b0;
    bus1.flush     = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b0;

    @(negedge CLK);
    check_eq("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("rst_count",     32'(bus0.count),     32'd0);
    check_eq("rst_in_ready",  32'(bus0.in_ready),  32'd1);
    @(negedge CLK);
    reset_n = 1'b1;

    // Test 1: async reset while three words are in flight
    for (int i = 0; i < 3; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = 8'hA0 + 8'(i);
      cycle();
    end
    bus0.in_valid = 1'b0;
    check_eq("t1_count3", 32'(bus0.count), 32'd3);
    reset_n = 1'b0;
    #1;
    check_eq("t1_out_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("t1_count",     32'(bus0.count),     32'd0);
    check_eq("t1_out_data",  32'(bus0.out_data),  32'h00);
    check_eq("t1_in_ready",  32'(bus0.in_ready),  32'd1);
    sb.delete();
    @(negedge CLK);
    reset_n = 1'b1;

    // Test 2: back-to-back stream with consumer always ready
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = 8'h11 * 8'(i + 1);
      cycle();
      check_eq("t2_latency", 32'(bus0.out_valid), 32'(i == 3));
    end
    bus0.in_valid = 1'b0;
    check_eq("t2_first", 32'(bus0.out_data), 32'h11);
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_nogap", 32'(bus0.out_valid), 32'd1);
      cycle();
    end
    check_eq("t2_empty", 32'(bus0.out_valid), 32'd0);

    // Test 3: fill under back-pressure, then push and pop together
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = 8'h11 * 8'(i + 1);
      cycle();
    end
    bus0.in_data = 8'h55;
    #1;
    check_eq("t3_full_in_ready", 32'(bus0.in_ready), 32'd0);
    check_eq("t3_full_count",    32'(bus0.count),    32'd4);
    cycle(3);
    bus0.out_ready = 1'b1;
    #1;
    check_eq("t3_pushpop_ready", 32'(bus0.in_ready), 32'd1);
    check_eq("t3_head",          32'(bus0.out_data), 32'h11);
    cycle(3);
    bus0.in_valid = 1'b0;
    drain();
    check_eq("t3_empty", 32'(bus0.out_valid), 32'd0);

    // Test 4: single word collapses through bubbles and then holds
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 8'h5A;
    cycle();
    bus0.in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check_eq("t4_valid", 32'(bus0.out_valid), 32'(k >= 3));
      if (k >= 3) check_eq("t4_hold", 32'(bus0.out_data), 32'h5A);
    end
    bus0.out_ready = 1'b1;
    cycle();
    check_eq("t4_popped", 32'(bus0.out_valid), 32'd0);

    // Test 5: flush with a word on offer
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = 8'h61 + 8'(i);
      cycle();
    end
    bus0.flush   = 1'b1;
    bus0.in_data = 8'h77;
    #1;
    check_eq("t5_flush_in_ready", 32'(bus0.in_ready), 32'd0);
    cycle(3);
    bus0.flush    = 1'b0;
    bus0.in_valid = 1'b0;
    check_eq("t5_out_valid", 32'(bus0.out_valid), 32'd0);
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_eq("t5_no_emerge", 32'(bus0.out_valid), 32'd0);
    end

    // Test 6: single-stage 16-bit pipe, simultaneous consume and load
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 16'hBEEF;
    bus1.out_ready = 1'b0;
    @(negedge CLK);
    check_eq("t6_valid",    32'(bus1.out_valid), 32'd1);
    check_eq("t6_beef",     32'(bus1.out_data),  32'hBEEF);
    check_eq("t6_count1",   32'(bus1.count),     32'd1);
    check_eq("t6_full_rdy", 32'(bus1.in_ready),  32'd0);
    bus1.in_data   = 16'hCAFE;
    bus1.out_ready = 1'b1;
    #1;
    check_eq("t6_pass_rdy", 32'(bus1.in_ready), 32'd1);
    @(negedge CLK);
    check_eq("t6_cafe",   32'(bus1.out_data),  32'hCAFE);
    check_eq("t6_count",  32'(bus1.count),     32'd1);
    check_eq("t6_valid2", 32'(bus1.out_valid), 32'd1);
    bus1.in_valid = 1'b0;
    @(negedge CLK);
    check_eq("t6_empty",     32'(bus1.out_valid), 32'd0);
    check_eq("t6_count0",    32'(bus1.count),     32'd0);
    check_eq("t6_keep_data", 32'(bus1.out_data),  32'hCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
